// File: rtl/bus_timer.sv
// Memory-mapped countdown timer on the CPU bridge: CTRL/PRESET/COUNT registers,
// a four-state countdown FSM and an interrupt request for one HWInt line.
module bus_timer #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  state_t                 state, state_nxt;
  logic                   en, en_nxt;
  logic [1:0]             mode, mode_nxt;
  logic                   im, im_nxt;
  logic [COUNT_WIDTH-1:0] preset, preset_nxt;
  logic [COUNT_WIDTH-1:0] count, count_nxt;
  logic                   pending, pending_nxt;

  logic wr_ok, ctrl_wr, preset_wr;

  assign wr_ok     = we && (be == 4'b1111);
  assign ctrl_wr   = wr_ok && (addr == 2'd0);
  assign preset_wr = wr_ok && (addr == 2'd1);

  // FSM update first, then CPU writes override the registers they touch.
  always_comb begin
    state_nxt   = state;
    en_nxt      = en;
    mode_nxt    = mode;
    im_nxt      = im;
    preset_nxt  = preset;
    count_nxt   = count;
    pending_nxt = pending;

    case (state)
      IDLE: begin
        if (en) state_nxt = LOAD;
      end
      LOAD: begin
        count_nxt = preset;
        state_nxt = CNT;
      end
      CNT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (count <= ONE) begin
          count_nxt = '0;
          state_nxt = INT;
        end else begin
          count_nxt = count - ONE;
        end
      end
      INT: begin
        if (mode == 2'd1) begin
          state_nxt = LOAD;
        end else begin
          en_nxt      = 1'b0;
          pending_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (ctrl_wr) begin
      en_nxt      = wdata[0];
      mode_nxt    = wdata[2:1];
      im_nxt      = wdata[3];
      pending_nxt = 1'b0;
      if (!wdata[0]) state_nxt = IDLE;
    end

    if (preset_wr) begin
      preset_nxt  = wdata[COUNT_WIDTH-1:0];
      pending_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      en      <= 1'b0;
      mode    <= 2'd0;
      im      <= 1'b0;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      en      <= en_nxt;
      mode    <= mode_nxt;
      im      <= im_nxt;
      preset  <= preset_nxt;
      count   <= count_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      2'd0:    rdata = {28'd0, im, mode, en};
      2'd1:    rdata = 32'(preset);
      2'd2:    rdata = 32'(count);
      default: rdata = 32'd0;
    endcase
  end

  assign irq = im && ((state == INT) || pending);

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: register access, countdown timing in one-shot
// and auto-reload modes, write filtering, pending masking and mid-count reset.
module tb_bus_timer;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int pulse[8];
  int pulseCount;

  bus_timer #(.COUNT_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .be    (be),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drives one bus write that lands on the next rising edge.
  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    addr  = a;
    wdata = d;
    be    = b;
    we    = 1'b1;
    tick();
    we    = 1'b0;
    be    = 4'b0000;
  endtask

  task automatic readReg(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  // Records the cycle index (1 = first edge after the call) of each cycle with irq high.
  task automatic waitPulses(input int n, input int budget);
    pulseCount = 0;
    for (int c = 1; c <= budget && pulseCount < n; c++) begin
      tick();
      if (irq) begin
        pulse[pulseCount] = c;
        pulseCount++;
      end
    end
    checkOutput("pulses_seen", 32'(pulseCount), 32'(n));
  endtask

  task automatic pollCount(input logic [31:0] target, input int budget);
    logic [31:0] v;
    bit found;
    found = 0;
    for (int c = 0; c < budget && !found; c++) begin
      tick();
      readReg(2'd2, v);
      if (v == target) found = 1;
    end
    checkOutput("count_reached", 32'(found), 32'd1);
  endtask

  initial begin
    logic [31:0] v;
    bit sawIrq;

    reset = 1'b1;
    we    = 1'b0;
    be    = 4'b0000;
    addr  = 2'd0;
    wdata = 32'd0;
    repeat (3) tick();
    reset = 1'b0;

    $display("[TB] reset state");
    for (int a = 0; a < 4; a++) begin
      readReg(2'(a), v);
      checkOutput($sformatf("reset_rd%0d", a), v, 32'd0);
    end
    checkOutput("reset_irq", 32'(irq), 32'd0);

    // One-shot: COUNT=5 after edge 2, 0 with irq after edge 7, then held.
    $display("[TB] mode0 one-shot");
    applyStimulus(2'd1, 32'd5, 4'b1111);
    readReg(2'd1, v);
    checkOutput("preset_wr", v, 32'd5);
    applyStimulus(2'd0, 32'h9, 4'b1111);
    tick();
    checkOutput("m0_irq_load", 32'(irq), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      readReg(2'd2, v);
      checkOutput($sformatf("m0_count%0d", k), v, 32'(5 - k));
      checkOutput($sformatf("m0_irq%0d", k), 32'(irq), (k == 5) ? 32'd1 : 32'd0);
    end
    tick();
    readReg(2'd0, v);
    checkOutput("m0_ctrl_after", v, 32'h8);
    repeat (3) tick();
    checkOutput("m0_irq_held", 32'(irq), 32'd1);
    applyStimulus(2'd0, 32'h0, 4'b1111);
    checkOutput("m0_irq_cleared", 32'(irq), 32'd0);

    // Auto-reload: pulses every 7 cycles, first at cycle 7 after the CTRL write.
    $display("[TB] mode1 auto-reload");
    applyStimulus(2'd0, 32'hB, 4'b1111);
    waitPulses(4, 40);
    checkOutput("m1_first", 32'(pulse[0]), 32'd7);
    for (int i = 1; i < 4; i++)
      checkOutput($sformatf("m1_period%0d", i), 32'(pulse[i] - pulse[i-1]), 32'd7);
    readReg(2'd0, v);
    checkOutput("m1_ctrl_en", v, 32'hB);

    // PRESET rewrite mid-count: current period ends from 4, next periods use 3.
    $display("[TB] preset change during count");
    pollCount(32'd4, 20);
    applyStimulus(2'd1, 32'd3, 4'b1111);
    waitPulses(3, 30);
    checkOutput("pc_first", 32'(pulse[0]), 32'd3);
    checkOutput("pc_period1", 32'(pulse[1] - pulse[0]), 32'd5);
    checkOutput("pc_period2", 32'(pulse[2] - pulse[1]), 32'd5);
    applyStimulus(2'd0, 32'h0, 4'b1111);
    checkOutput("pc_stop_irq", 32'(irq), 32'd0);

    // Write filtering and masked pending, from a clean reset.
    $display("[TB] write filtering and masked interrupt");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(2'd1, 32'd3, 4'b1111);
    applyStimulus(2'd1, 32'h77, 4'b0011);
    readReg(2'd1, v);
    checkOutput("partial_preset", v, 32'd3);
    applyStimulus(2'd2, 32'h55, 4'b1111);
    readReg(2'd2, v);
    checkOutput("count_ro", v, 32'd0);
    applyStimulus(2'd0, 32'h9, 4'b0111);
    readReg(2'd0, v);
    checkOutput("partial_ctrl", v, 32'd0);
    applyStimulus(2'd3, 32'hFFFF_FFFF, 4'b1111);
    readReg(2'd3, v);
    checkOutput("reserved_rd", v, 32'd0);
    applyStimulus(2'd0, 32'h1, 4'b1111);
    sawIrq = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (irq) sawIrq = 1;
    end
    checkOutput("masked_irq", 32'(sawIrq), 32'd0);
    readReg(2'd0, v);
    checkOutput("masked_ctrl_done", v, 32'd0);
    readReg(2'd2, v);
    checkOutput("masked_count", v, 32'd0);
    applyStimulus(2'd0, 32'h8, 4'b1111);
    checkOutput("masked_im_on", 32'(irq), 32'd0);
    tick();
    checkOutput("masked_im_on2", 32'(irq), 32'd0);

    // PRESET=0 acts like 1: INT on the first CNT edge (edge 3).
    $display("[TB] preset zero");
    applyStimulus(2'd1, 32'd0, 4'b1111);
    applyStimulus(2'd0, 32'h9, 4'b1111);
    tick();
    tick();
    checkOutput("p0_irq_e2", 32'(irq), 32'd0);
    tick();
    checkOutput("p0_irq_e3", 32'(irq), 32'd1);
    applyStimulus(2'd0, 32'h0, 4'b1111);

    // Reset mid-count returns everything to zero with no later interrupt.
    $display("[TB] reset mid-count");
    applyStimulus(2'd1, 32'd5, 4'b1111);
    applyStimulus(2'd0, 32'h9, 4'b1111);
    pollCount(32'd2, 20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int a = 0; a < 3; a++) begin
      readReg(2'(a), v);
      checkOutput($sformatf("mid_reset_rd%0d", a), v, 32'd0);
    end
    checkOutput("mid_reset_irq", 32'(irq), 32'd0);
    sawIrq = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (irq) sawIrq = 1;
    end
    checkOutput("mid_reset_no_irq", 32'(sawIrq), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
